// File: rtl/led_blink_pkg.sv
// Shared types and constants for the multi-channel LED blink controller.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  localparam int unsigned BURST_W = 8;
  localparam int unsigned PWM_W   = 4;
  localparam logic [PWM_W-1:0] DUTY_RST = '1;

endpackage

// File: rtl/led_blink_ch.sv
// One LED channel: mode/half/burst registers, tick-driven toggler and burst counter.
// Holds a per-channel duty register when LED_BLINK_DIM_EN is defined.
module led_blink_ch
  import led_blink_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic               tick,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
`ifdef LED_BLINK_DIM_EN
  input  logic [PWM_W-1:0]   cfg_duty,
  output logic [PWM_W-1:0]   duty,
`endif
  output logic               lit,
  output logic               busy,
  output logic               done
);

  mode_e               mode_q, mode_d;
  logic [CNT_W-1:0]    half_q, half_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BURST_W-1:0]  rem_q, rem_d;
  logic                lit_d, busy_d, done_d;
`ifdef LED_BLINK_DIM_EN
  logic [PWM_W-1:0]    duty_d;
`endif

  // Next-state: a write always wins over a coincident tick.
  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    lit_d  = lit;
    busy_d = busy;
    done_d = 1'b0;
`ifdef LED_BLINK_DIM_EN
    duty_d = duty;
`endif
    if (we) begin
      mode_d = mode_e'(cfg_mode);
      half_d = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
      cnt_d  = '0;
      rem_d  = cfg_burst;
`ifdef LED_BLINK_DIM_EN
      duty_d = cfg_duty;
`endif
      case (mode_e'(cfg_mode))
        MODE_OFF: begin
          lit_d  = 1'b0;
          busy_d = 1'b0;
        end
        MODE_ON: begin
          lit_d  = 1'b1;
          busy_d = 1'b0;
        end
        MODE_BLINK: begin
          lit_d  = 1'b1;
          busy_d = 1'b1;
        end
        MODE_BURST: begin
          if (cfg_burst == '0) begin
            mode_d = MODE_OFF;
            lit_d  = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            lit_d  = 1'b1;
            busy_d = 1'b1;
          end
        end
      endcase
    end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
      if (cnt_q == half_q - CNT_W'(1)) begin
        cnt_d = '0;
        lit_d = ~lit;
        // Falling edges consume burst pulses; the last one retires the channel.
        if (mode_q == MODE_BURST && lit) begin
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            mode_d = MODE_OFF;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      half_q <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      lit    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef LED_BLINK_DIM_EN
      duty   <= DUTY_RST;
`endif
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      lit    <= lit_d;
      busy   <= busy_d;
      done   <= done_d;
`ifdef LED_BLINK_DIM_EN
      duty   <= duty_d;
`endif
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: shared prescaler, write decode, NUM_CH channels.
// Define LED_BLINK_DIM_EN to add per-channel 4-bit PWM dimming (cfg_duty).
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned CNT_W    = 32,
  parameter  int unsigned PRESCALE = 10,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
`ifdef LED_BLINK_DIM_EN
  input  logic [PWM_W-1:0]   cfg_duty,
`endif
  output logic [NUM_CH-1:0]  led,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  done
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_c;
  logic [NUM_CH-1:0] lit_w;
  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] done_w;
`ifdef LED_BLINK_DIM_EN
  logic [PWM_W-1:0]  duty_w [NUM_CH];
`endif

  // Free-running prescaler; writes never disturb its phase.
  assign tick_c = (pre_q == PRE_W'(PRESCALE - 1));

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (tick_c) pre_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_blink_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (cfg_we && (cfg_ch == CH_W'(i))),
      .tick      (tick_c),
      .cfg_mode  (cfg_mode),
      .cfg_half  (cfg_half),
      .cfg_burst (cfg_burst),
`ifdef LED_BLINK_DIM_EN
      .cfg_duty  (cfg_duty),
      .duty      (duty_w[i]),
`endif
      .lit       (lit_w[i]),
      .busy      (busy_w[i]),
      .done      (done_w[i])
    );
  end

  assign busy = busy_w;
  assign done = done_w;

`ifdef LED_BLINK_DIM_EN
  logic [PWM_W-1:0]  pwm_q;
  logic [NUM_CH-1:0] led_d;
  logic [NUM_CH-1:0] led_q;

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      led_d[i] = lit_w[i] & (pwm_q <= duty_w[i]);
    end
  end

  // Shared PWM phase and registered dimmed output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
      led_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
      led_q <= led_d;
    end
  end

  assign led = led_q;
`else
  assign led = lit_w;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: driver queues expected outputs, monitor compares.
module tb_led_blink_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_half;
  logic [7:0]  cfg_burst;
  logic [2:0]  led, busy, done;

  logic        b_we;
  logic [0:0]  b_ch;
  logic [1:0]  b_mode;
  logic [7:0]  b_half;
  logic [7:0]  b_burst;
  logic [1:0]  b_led, b_busy, b_done;
`ifdef LED_BLINK_DIM_EN
  logic [3:0]  cfg_duty = 4'hF;
`endif

  always #5 clk = ~clk;

  led_blink_ctrl #(.NUM_CH(3), .CNT_W(16), .PRESCALE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst),
`ifdef LED_BLINK_DIM_EN
    .cfg_duty(cfg_duty),
`endif
    .led(led), .busy(busy), .done(done));

  led_blink_ctrl #(.NUM_CH(2), .CNT_W(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_we(b_we), .cfg_ch(b_ch), .cfg_mode(b_mode),
    .cfg_half(b_half), .cfg_burst(b_burst),
`ifdef LED_BLINK_DIM_EN
    .cfg_duty(cfg_duty),
`endif
    .led(b_led), .busy(b_busy), .done(b_done));

  typedef struct {
    bit         c;
    bit         sel;
    logic [2:0] led;
    logic [2:0] busy;
    logic [2:0] done;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] e_led, e_busy, e_done;
  int         b_pre;

  // Reference prescaler phase for the PRESCALE=4 instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_pre <= 0;
    else        b_pre <= (b_pre == 3) ? 0 : b_pre + 1;
  end

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: led/busy/done got %b required %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit sel, input bit c, input string nm);
    exp_t e;
    e.c = c; e.sel = sel; e.led = e_led; e.busy = e_busy; e.done = e_done; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    b_we   = 1'b0;
  endtask

  task automatic wr_a(input logic [1:0] ch, input logic [1:0] mode,
                      input logic [15:0] half, input logic [7:0] burst);
    cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_burst = burst; cfg_we = 1'b1;
  endtask

  task automatic wr_b(input logic [0:0] ch, input logic [1:0] mode,
                      input logic [7:0] half, input logic [7:0] burst);
    b_ch = ch; b_mode = mode; b_half = half; b_burst = burst; b_we = 1'b1;
  endtask

  // Monitor: one queued expectation per clock, sampled just after the edge.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        m = q.pop_front();
        if (m.c) begin
          if (m.sel) chk(m.name, {1'b0, b_led, 1'b0, b_busy, 1'b0, b_done}, {m.led, m.busy, m.done});
          else       chk(m.name, {led, busy, done}, {m.led, m.busy, m.done});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_burst = '0;
    b_we = 1'b0; b_ch = '0; b_mode = '0; b_half = '0; b_burst = '0;
    e_led = '0; e_busy = '0; e_done = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_a", {led, busy, done}, 9'd0);
    chk("reset_b", {1'b0, b_led, 1'b0, b_busy, 1'b0, b_done}, 9'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b1, "idle");

    wr_a(2'd2, 2'd1, 16'd5, 8'd0);
    e_led = 3'b100;
    cyc(1'b0, 1'b1, "on_ch2");
    cyc(1'b0, 1'b1, "on_hold");

    wr_a(2'd0, 2'd2, 16'd3, 8'd0);
    for (int k = 0; k < 12; k++) begin
      e_led[0] = ((k / 3) % 2 == 0);
      e_busy[0] = 1'b1;
      cyc(1'b0, 1'b1, "blink_h3");
    end

    wr_a(2'd0, 2'd0, 16'd3, 8'd0);
    e_led[0] = 1'b0; e_busy[0] = 1'b0;
    cyc(1'b0, 1'b1, "off_ch0");
    cyc(1'b0, 1'b1, "off_hold");

    wr_a(2'd1, 2'd3, 16'd2, 8'd3);
    for (int k = 0; k < 14; k++) begin
      e_led[1]  = (k < 10) && ((k / 2) % 2 == 0);
      e_busy[1] = (k < 10);
      e_done[1] = (k == 10);
      cyc(1'b0, 1'b1, "burst_h2n3");
    end

    wr_a(2'd0, 2'd2, 16'd0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      e_led[0] = (k % 2 == 0);
      e_busy[0] = 1'b1;
      cyc(1'b0, 1'b1, "blink_h0");
    end
    wr_a(2'd0, 2'd0, 16'd0, 8'd0);
    e_led[0] = 1'b0; e_busy[0] = 1'b0;
    cyc(1'b0, 1'b1, "off_ch0b");

    wr_a(2'd1, 2'd3, 16'd5, 8'd0);
    e_done[1] = 1'b1;
    cyc(1'b0, 1'b1, "burst0_done");
    e_done[1] = 1'b0;
    cyc(1'b0, 1'b1, "burst0_after");
    cyc(1'b0, 1'b1, "burst0_after");

    wr_a(2'd1, 2'd3, 16'd2, 8'd2);
    for (int k = 0; k < 3; k++) begin
      e_led[1] = (k < 2);
      e_busy[1] = 1'b1;
      cyc(1'b0, 1'b1, "abort_run");
    end
    wr_a(2'd1, 2'd0, 16'd2, 8'd0);
    e_led[1] = 1'b0; e_busy[1] = 1'b0;
    repeat (6) cyc(1'b0, 1'b1, "abort_nodone");

    wr_a(2'd3, 2'd1, 16'd1, 8'd0);
    repeat (3) cyc(1'b0, 1'b1, "bad_ch");

    // PRESCALE=4 instance: rewrite mid-blink on a tick edge.
    wr_b(1'b0, 2'd2, 8'd2, 8'd0);
    repeat (7) cyc(1'b1, 1'b0, "b_pre");
    for (int g = 0; g < 8 && b_pre != 3; g++) cyc(1'b1, 1'b0, "b_align");
    if (b_pre != 3) begin
      n_vec++; n_err++;
      $display("FAIL b_align: prescaler phase %0d required 3", b_pre);
    end
    wr_b(1'b0, 2'd2, 8'd2, 8'd0);
    e_busy = 3'b001; e_done = 3'b000;
    for (int k = 0; k < 18; k++) begin
      e_led = {2'b00, (k < 8) || (k >= 16)};
      cyc(1'b1, 1'b1, "b_tick_write");
    end
    e_led = 3'b100; e_busy = 3'b000; e_done = 3'b000;

    wr_a(2'd0, 2'd2, 16'd3, 8'd0);
    e_led = 3'b101; e_busy = 3'b001;
    cyc(1'b0, 1'b1, "pre_rst");
    cyc(1'b0, 1'b1, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {led, busy, done}, 9'd0);
    chk("async_rst_b", {1'b0, b_led, 1'b0, b_busy, 1'b0, b_done}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e_led = '0; e_busy = '0; e_done = '0;
    repeat (4) cyc(1'b0, 1'b1, "post_rst");
    repeat (2) cyc(1'b1, 1'b1, "post_rst_b");

    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
